cnt_calendar_bcd: RTL
=====================

Name: cnt_calendar_bcd

Overview:
Parametrised BCD calendar counter holding day, month and year. Advances one day per qualified tick from the time-of-day chain. Generalises the stand-alone day counter:
- leap year computed internally from the year
- configurable year width
- up/down counting for adjust mode
- validated parallel load

Sits above the hour counter in the clock datapath and feeds the display mux.

Parameters:
YEAR_DIGITS, 2, number of BCD year digits; legal values 2 or 4 only.
YEAR_RST, 16'h2024, reset year in BCD; low 4*YEAR_DIGITS bits used.
MONTH_RST, 8'h01, reset month in BCD.
DAY_RST, 8'h01, reset day in BCD; must be valid for MONTH_RST/YEAR_RST.

Ports:
CLK  in  1  system clock; all state on rising edge.
RESET  in  1  synchronous, active-high reset.
ENABLE  in  1  global count enable.
CARRY_in  in  1  day tick from hour counter; counts only with ENABLE=1.
DIR  in  1  1 = count up, 0 = count down.
LOAD  in  1  parallel load strobe.
LOAD_DAY  in  8  BCD day to load.
LOAD_MONTH  in  8  BCD month to load.
LOAD_YEAR  in  4*YEAR_DIGITS  BCD year to load.
DAY  out  8  BCD day, 01..28/29/30/31.
MONTH  out  8  BCD month, 01..12.
YEAR  out  4*YEAR_DIGITS  BCD year.
IS_LEAP  out  1  combinational leap flag of current YEAR.
CARRY_out  out  1  combinational year-boundary flag for the current cycle's step.
LOAD_ERR  out  1  registered one-cycle pulse: last LOAD rejected.

Behaviour:
- Reset (RESET=1 at CLK edge):
  - DAY=DAY_RST, MONTH=MONTH_RST, YEAR=YEAR_RST[4*YEAR_DIGITS-1:0], LOAD_ERR=0.
  - Overrides LOAD and tick.
- Priority per edge: RESET > LOAD > step > hold.
- step = ENABLE & CARRY_in & ~LOAD.
- All registers update on the edge after the qualifying cycle (latency 1).
- Month length (ML):
  - 31 for months 01,03,05,07,08,10,12.
  - 30 for months 04,06,09,11.
  - 29 for month 02 when leap, 28 otherwise.
- Leap rule, YEAR_DIGITS=2: year mod 4 == 0. BCD test: (tens even and ones in {0,4,8}) or (tens odd and ones in {2,6}). Year 00 counts as leap.
- Leap rule, YEAR_DIGITS=4: low pair divisible by 4 and low pair != 00; or low pair == 00 and high pair divisible by 4. Gregorian: 1900 not leap, 2000 leap.
- Step up:
  - Day < ML: day+1 with BCD ones wrap 9->0 and tens increment.
  - Day == ML: day=01, month+1.
  - Month 12 with day 31: month=01, year+1.
  - Year wraps all-9s -> all-0s.
- Step down:
  - Day > 01: day-1 with BCD borrow.
  - Day == 01: month-1 and day = ML(previous month).
  - Previous month is evaluated with the current year, except January -> December, which uses year-1; December is always 31.
  - Month 01 day 01: month=12, day=31, year-1; year all-0s wraps to all-9s.
- CARRY_out = ENABLE & CARRY_in & ~LOAD & ((DIR & MONTH==12 & DAY==31) | (~DIR & MONTH==01 & DAY==01)).
- Load is accepted only when all of the following hold:
  - every nibble of every load field is <=9;
  - LOAD_MONTH is in 01..12;
  - LOAD_DAY is in 01..ML(LOAD_MONTH, LOAD_YEAR).
- Load accepted: all three fields written.
- Load rejected: state held, LOAD_ERR=1 for exactly one cycle.
- LOAD_ERR is 0 in every cycle without a rejected load.
- A stored state is never an invalid date; no clamping is needed during counting.

Optional Feature:
CAL_WEEKDAY_EN
- Defined:
  - Adds output WEEKDAY [2:0] (0=Sunday..6=Saturday) and input LOAD_WDAY [2:0].
  - WEEKDAY resets to 0.
  - On step: +1 mod 7 when up, -1 mod 7 when down.
  - Loaded from LOAD_WDAY on an accepted load; a value of 7 makes the load rejected.
- Not defined: neither port exists and no weekday logic is built.

Decomposition:
- Package calendar_pkg holds:
  - BCD month constants (MON_JAN..MON_DEC);
  - day-count constants 8'h28, 8'h29, 8'h30, 8'h31;
  - a BCD increment/decrement-digit function;
  - the leap-test function for a BCD year pair.
- One sub-module, cal_month_len: combinational; inputs month[7:0] and is_leap; output BCD ML[7:0].
- cal_month_len is instantiated three times: current month, previous month, load check.

Test Plan:
1. Leap and non-leap February, up count:
   - YEAR_DIGITS=2, load 2024-02-28, tick -> 02-29, IS_LEAP=1.
   - Tick -> 03-01.
   - Load 2023-02-28, tick -> 03-01.
2. Year rollover up:
   - Load 99-12-31, DIR=1, tick -> CARRY_out=1 during the tick cycle.
   - Next state 00-01-01, IS_LEAP=1.
3. Down count across month and year:
   - Load 2024-03-01, DIR=0, tick -> 02-29.
   - Load 2025-01-01, tick -> 2024-12-31, CARRY_out=1.
4. Gregorian century rule:
   - YEAR_DIGITS=4, load 1900-02-28, tick -> 1900-03-01.
   - Load 2000-02-28, tick -> 2000-02-29.
5. Load validation:
   - LOAD 2023-02-29 -> state unchanged, LOAD_ERR=1 for one cycle.
   - LOAD month 8'h13 -> rejected.
   - LOAD day 8'h1A -> rejected.
   - LOAD+tick same cycle with a valid date -> load wins, no step.
6. Gating and reset:
   - CARRY_in=1 with ENABLE=0 -> no change.
   - RESET asserted in the same cycle as LOAD and a tick -> outputs return to reset values, LOAD_ERR=0.
   - With CAL_WEEKDAY_EN: WEEKDAY 6 + up tick -> 0; WEEKDAY 0 + down tick -> 6.

Source files
------------

// File: rtl/calendar_pkg.sv
// Shared constants and BCD helpers for the calendar counter: month codes,
// month-length values, digit stepping and Gregorian leap tests.
package calendar_pkg;

    localparam logic [7:0] MON_JAN = 8'h01;
    localparam logic [7:0] MON_FEB = 8'h02;
    localparam logic [7:0] MON_MAR = 8'h03;
    localparam logic [7:0] MON_APR = 8'h04;
    localparam logic [7:0] MON_MAY = 8'h05;
    localparam logic [7:0] MON_JUN = 8'h06;
    localparam logic [7:0] MON_JUL = 8'h07;
    localparam logic [7:0] MON_AUG = 8'h08;
    localparam logic [7:0] MON_SEP = 8'h09;
    localparam logic [7:0] MON_OCT = 8'h10;
    localparam logic [7:0] MON_NOV = 8'h11;
    localparam logic [7:0] MON_DEC = 8'h12;

    localparam logic [7:0] DAYS_28 = 8'h28;
    localparam logic [7:0] DAYS_29 = 8'h29;
    localparam logic [7:0] DAYS_30 = 8'h30;
    localparam logic [7:0] DAYS_31 = 8'h31;
    localparam logic [7:0] DAY_ONE = 8'h01;

    // carry is the ripple into the next digit: 9->0 going up, 0->9 going down
    typedef struct packed {
        logic       carry;
        logic [3:0] digit;
    } bcd_digit_t;

    function automatic bcd_digit_t bcd_digit_step(input logic [3:0] d, input logic up);
        bcd_digit_t r;
        if (up) begin
            r.carry = (d == 4'd9);
            r.digit = (d == 4'd9) ? 4'd0 : d + 4'd1;
        end else begin
            r.carry = (d == 4'd0);
            r.digit = (d == 4'd0) ? 4'd9 : d - 4'd1;
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_byte_step(input logic [7:0] v, input logic up);
        bcd_digit_t lo;
        bcd_digit_t hi;
        lo = bcd_digit_step(v[3:0], up);
        hi = bcd_digit_step(v[7:4], up);
        return {(lo.carry ? hi.digit : v[7:4]), lo.digit};
    endfunction

    function automatic logic bcd_byte_valid(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Divisible by 4 for a BCD pair; 00 counts as divisible
    function automatic logic leap_pair(input logic [7:0] p);
        if (!p[4])
            return (p[3:0] == 4'd0) || (p[3:0] == 4'd4) || (p[3:0] == 4'd8);
        else
            return (p[3:0] == 4'd2) || (p[3:0] == 4'd6);
    endfunction

    function automatic logic leap_year4(input logic [15:0] y);
        if (y[7:0] != 8'h00)
            return leap_pair(y[7:0]);
        else
            return leap_pair(y[15:8]);
    endfunction

endpackage

// File: rtl/cal_month_len.sv
// Combinational BCD month length lookup; February follows the supplied leap flag.
module cal_month_len
    import calendar_pkg::*;
(
    input  logic [7:0] month,
    input  logic       is_leap,
    output logic [7:0] ml
);

    // Out-of-range month codes fall to 31; callers range-check months separately
    always_comb begin
        ml = DAYS_31;
        case (month)
            MON_JAN, MON_MAR, MON_MAY, MON_JUL,
            MON_AUG, MON_OCT, MON_DEC: ml = DAYS_31;
            MON_APR, MON_JUN, MON_SEP, MON_NOV: ml = DAYS_30;
            MON_FEB: ml = is_leap ? DAYS_29 : DAYS_28;
            default: ml = DAYS_31;
        endcase
    end

endmodule

// File: rtl/cnt_calendar_bcd.sv
// BCD day/month/year calendar counter with up/down stepping and validated load.
// Define CAL_WEEKDAY_EN to add the WEEKDAY counter and LOAD_WDAY input.
module cnt_calendar_bcd
    import calendar_pkg::*;
#(
    parameter int         YEAR_DIGITS = 2,
    parameter logic [15:0] YEAR_RST   = 16'h2024,
    parameter logic [7:0]  MONTH_RST  = 8'h01,
    parameter logic [7:0]  DAY_RST    = 8'h01
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     ENABLE,
    input  logic                     CARRY_in,
    input  logic                     DIR,
    input  logic                     LOAD,
    input  logic [7:0]               LOAD_DAY,
    input  logic [7:0]               LOAD_MONTH,
    input  logic [4*YEAR_DIGITS-1:0] LOAD_YEAR,
    output logic [7:0]               DAY,
    output logic [7:0]               MONTH,
    output logic [4*YEAR_DIGITS-1:0] YEAR,
    output logic                     IS_LEAP,
    output logic                     CARRY_out,
    output logic                     LOAD_ERR
`ifdef CAL_WEEKDAY_EN
    ,
    input  logic [2:0]               LOAD_WDAY,
    output logic [2:0]               WEEKDAY
`endif
);

    localparam int YW = 4 * YEAR_DIGITS;

    logic          load_leap;
    logic          step;
    logic          at_boundary;
    logic [7:0]    prev_month;
    logic [7:0]    ml_cur;
    logic [7:0]    ml_prev;
    logic [7:0]    ml_load;
    logic [YW-1:0] year_step;
    logic [7:0]    day_nxt;
    logic [7:0]    month_nxt;
    logic [YW-1:0] year_nxt;
    logic          year_digits_ok;
    logic          load_ok;

    // Four-digit years apply the century rule; two-digit years are plain mod 4
    if (YEAR_DIGITS == 4) begin : g_leap4
        assign IS_LEAP   = leap_year4(YEAR);
        assign load_leap = leap_year4(LOAD_YEAR);
    end else begin : g_leap2
        assign IS_LEAP   = leap_pair(YEAR[7:0]);
        assign load_leap = leap_pair(LOAD_YEAR[7:0]);
    end

    // A tick counts only when enabled and not displaced by a load on the same edge
    assign step        = ENABLE & CARRY_in & ~LOAD;
    assign at_boundary = DIR ? ((MONTH == MON_DEC) && (DAY == DAYS_31))
                             : ((MONTH == MON_JAN) && (DAY == DAY_ONE));
    assign CARRY_out   = step & at_boundary;

    // December is always 31 days, so the current year's leap flag is safe here
    assign prev_month = (MONTH == MON_JAN) ? MON_DEC : bcd_byte_step(MONTH, 1'b0);

    cal_month_len u_ml_cur (
        .month   (MONTH),
        .is_leap (IS_LEAP),
        .ml      (ml_cur)
    );

    cal_month_len u_ml_prev (
        .month   (prev_month),
        .is_leap (IS_LEAP),
        .ml      (ml_prev)
    );

    cal_month_len u_ml_load (
        .month   (LOAD_MONTH),
        .is_leap (load_leap),
        .ml      (ml_load)
    );

    // Ripple a single BCD step through the year digits in the DIR direction
    always_comb begin
        bcd_digit_t dstep;
        logic       ripple;
        year_step = YEAR;
        ripple    = 1'b1;
        for (int i = 0; i < YEAR_DIGITS; i++) begin
            dstep = bcd_digit_step(YEAR[4*i +: 4], DIR);
            if (ripple)
                year_step[4*i +: 4] = dstep.digit;
            ripple = ripple & dstep.carry;
        end
    end

    always_comb begin
        day_nxt   = DAY;
        month_nxt = MONTH;
        year_nxt  = YEAR;
        if (DIR) begin
            if (DAY != ml_cur) begin
                day_nxt = bcd_byte_step(DAY, 1'b1);
            end else begin
                day_nxt = DAY_ONE;
                if (MONTH == MON_DEC) begin
                    month_nxt = MON_JAN;
                    year_nxt  = year_step;
                end else begin
                    month_nxt = bcd_byte_step(MONTH, 1'b1);
                end
            end
        end else begin
            if (DAY != DAY_ONE) begin
                day_nxt = bcd_byte_step(DAY, 1'b0);
            end else begin
                month_nxt = prev_month;
                day_nxt   = ml_prev;
                if (MONTH == MON_JAN)
                    year_nxt = year_step;
            end
        end
    end

    always_comb begin
        year_digits_ok = 1'b1;
        for (int i = 0; i < YEAR_DIGITS; i++) begin
            if (LOAD_YEAR[4*i +: 4] > 4'd9)
                year_digits_ok = 1'b0;
        end
    end

    // BCD codes compare correctly as binary once every nibble is a valid digit
    always_comb begin
        load_ok = year_digits_ok
                & bcd_byte_valid(LOAD_DAY)
                & bcd_byte_valid(LOAD_MONTH)
                & (LOAD_MONTH != 8'h00) & (LOAD_MONTH <= MON_DEC)
                & (LOAD_DAY != 8'h00) & (LOAD_DAY <= ml_load);
`ifdef CAL_WEEKDAY_EN
        load_ok = load_ok & (LOAD_WDAY != 3'd7);
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            DAY      <= DAY_RST;
            MONTH    <= MONTH_RST;
            YEAR     <= YEAR_RST[YW-1:0];
            LOAD_ERR <= 1'b0;
        end else begin
            LOAD_ERR <= LOAD & ~load_ok;
            if (LOAD) begin
                if (load_ok) begin
                    DAY   <= LOAD_DAY;
                    MONTH <= LOAD_MONTH;
                    YEAR  <= LOAD_YEAR;
                end
            end else if (step) begin
                DAY   <= day_nxt;
                MONTH <= month_nxt;
                YEAR  <= year_nxt;
            end
        end
    end

`ifdef CAL_WEEKDAY_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            WEEKDAY <= 3'd0;
        end else if (LOAD) begin
            if (load_ok)
                WEEKDAY <= LOAD_WDAY;
        end else if (step) begin
            if (DIR)
                WEEKDAY <= (WEEKDAY == 3'd6) ? 3'd0 : WEEKDAY + 3'd1;
            else
                WEEKDAY <= (WEEKDAY == 3'd0) ? 3'd6 : WEEKDAY - 3'd1;
        end
    end
`endif

endmodule
